// File: rtl/mem_bus_ctl_pkg.sv
// Shared types for the memory bus controller: FSM encoding, transaction kinds,
// byte-lane enables and the lane-select helper.
package mem_bus_ctl_pkg;

    typedef enum logic [1:0] {
        MB_IDLE = 2'b00,
        MB_BUS  = 2'b01,
        MB_DONE = 2'b10
    } mb_state_e;

    typedef enum logic [1:0] {
        K_FETCH = 2'b00,
        K_LOAD  = 2'b01,
        K_STORE = 2'b10
    } mb_kind_e;

    localparam logic [1:0]  BE_LO    = 2'b01;
    localparam logic [1:0]  BE_HI    = 2'b10;
    localparam logic [1:0]  BE_WORD  = 2'b11;
    localparam logic [15:0] ERR_WORD = 16'hFFFF;

    // Everything about an accepted request except its address.
    typedef struct packed {
        mb_kind_e    kind;
        logic        byte_acc;
        logic        lane_hi;
        logic [1:0]  be;
        logic [15:0] wdata;
    } mb_txn_t;

    function automatic logic [7:0] lane_sel(input logic hi, input logic [15:0] w);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/mem_bus_ctl_if.sv
// External 16-bit memory bus: one req/ack handshake shared by fetch, load and store.
interface mem_bus_ctl_if #(
    parameter int ADDR_W = 16
);
    logic              bus_req;
    logic              bus_we;
    logic [1:0]        bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [15:0]       bus_wdata;
    logic [15:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane shaping: store replication, byte enables and zero-extended load extraction.
// Purely combinational so other bus masters can share it.
module mem_byte_lane
    import mem_bus_ctl_pkg::*;
(
    input  logic        i_byte,
    input  logic        i_lane_hi,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_rdata,
    output logic [1:0]  o_be,
    output logic [15:0] o_wdata,
    output logic [15:0] o_rdata
);
    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        if (i_byte) begin
            o_be    = i_lane_hi ? BE_HI : BE_LO;
            o_wdata = {2{i_wdata[7:0]}};
            o_rdata = {8'h00, lane_sel(i_lane_hi, i_rdata)};
        end
    end
endmodule

// File: rtl/mem_bus_ctl.sv
// Memory-side stage: sole owner of the external bus, arbitrates data over fetch,
// stalls control via mem_wait and aborts an unacknowledged request after TIMEOUT cycles.
module mem_bus_ctl
    import mem_bus_ctl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [15:0]   pc,
    input  logic          data_rd,
    input  logic          data_wr,
    input  logic          data_byte,
    input  logic [15:0]   data_addr,
    input  logic [15:0]   data_wdata,
    output logic          mem_wait,
    output logic [15:0]   instr_o,
    output logic [15:0]   rdata_o,
    output logic          bus_err,
    mem_bus_ctl_if.master bus
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mb_state_e         r_state, w_next;
    mb_txn_t           r_txn;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_cnt;
    logic [15:0]       r_instr, r_rdata;
    logic              r_err;

    logic              w_data_req, w_on_bus, w_timeout, w_pend_fetch;
    logic              w_lane_byte, w_lane_hi;
    logic [1:0]        w_lane_be;
    logic [15:0]       w_lane_wdata, w_lane_rdata;
    logic              w_bus_req, w_bus_we;
    logic [1:0]        w_bus_be;
    logic [ADDR_W-1:0] w_bus_addr;
    logic [15:0]       w_bus_wdata;

    assign w_data_req = data_rd | data_wr;

    // In IDLE the lane logic shapes the incoming request; in BUS it extracts from bus_rdata.
    assign w_lane_byte = (r_state == MB_IDLE) ? data_byte    : r_txn.byte_acc;
    assign w_lane_hi   = (r_state == MB_IDLE) ? data_addr[0] : r_txn.lane_hi;

    mem_byte_lane u_lane (
        .i_byte    (w_lane_byte),
        .i_lane_hi (w_lane_hi),
        .i_wdata   (data_wdata),
        .i_rdata   (bus.bus_rdata),
        .o_be      (w_lane_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_lane_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= MB_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MB_IDLE: if (w_data_req | fetch_req)       w_next = MB_BUS;
            MB_BUS:  if (bus.bus_ack | w_timeout)      w_next = MB_DONE;
            MB_DONE:                                   w_next = MB_IDLE;
            default:                                   w_next = MB_IDLE;
        endcase
    end

    always_comb begin
        w_on_bus     = (r_state == MB_BUS);
        w_timeout    = w_on_bus & ~bus.bus_ack & (r_cnt == TO_LAST);
        // A fetch that lost arbitration keeps control stalled through the data DONE cycle.
        w_pend_fetch = (r_state == MB_DONE) & fetch_req & (r_txn.kind != K_FETCH);
        mem_wait     = rst & ((((r_state != MB_DONE) & (w_data_req | fetch_req))) | w_pend_fetch);
        w_bus_req    = w_on_bus;
        w_bus_we     = w_on_bus & (r_txn.kind == K_STORE);
        w_bus_be     = w_on_bus ? r_txn.be    : 2'b00;
        w_bus_addr   = w_on_bus ? r_addr      : '0;
        w_bus_wdata  = w_on_bus ? r_txn.wdata : 16'h0000;
    end

    assign bus.bus_req   = w_bus_req;
    assign bus.bus_we    = w_bus_we;
    assign bus.bus_be    = w_bus_be;
    assign bus.bus_addr  = w_bus_addr;
    assign bus.bus_wdata = w_bus_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txn   <= '0;
            r_addr  <= '0;
            r_cnt   <= 8'd0;
            r_instr <= 16'h0000;
            r_rdata <= 16'h0000;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_timeout;
            case (r_state)
                MB_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_data_req) begin
                        r_txn.kind     <= data_wr ? K_STORE : K_LOAD;
                        r_txn.byte_acc <= data_byte;
                        r_txn.lane_hi  <= data_addr[0];
                        r_txn.be       <= w_lane_be;
                        r_txn.wdata    <= w_lane_wdata;
                        r_addr         <= ADDR_W'(data_addr & 16'hFFFE);
                    end else if (fetch_req) begin
                        r_txn.kind     <= K_FETCH;
                        r_txn.byte_acc <= 1'b0;
                        r_txn.lane_hi  <= 1'b0;
                        r_txn.be       <= BE_WORD;
                        r_txn.wdata    <= 16'h0000;
                        r_addr         <= ADDR_W'(pc & 16'hFFFE);
                    end
                end
                MB_BUS: begin
                    if (bus.bus_ack) begin
                        if (r_txn.kind == K_FETCH)     r_instr <= bus.bus_rdata;
                        else if (r_txn.kind == K_LOAD) r_rdata <= w_lane_rdata;
                    end else if (w_timeout) begin
                        if (r_txn.kind == K_FETCH)     r_instr <= ERR_WORD;
                        else if (r_txn.kind == K_LOAD) r_rdata <= ERR_WORD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_o = r_instr;
    assign rdata_o = r_rdata;
    assign bus_err = r_err;

endmodule

// File: tb/tb_mem_bus_ctl.sv
// Self-checking bench for mem_bus_ctl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_bus_ctl;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, data_rd, data_wr, data_byte;
    logic [15:0] pc, data_addr, data_wdata;
    logic        mem_wait, bus_err;
    logic [15:0] instr_o, rdata_o;

    mem_bus_ctl_if #(.ADDR_W(16)) bus ();

    mem_bus_ctl #(.ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .data_rd    (data_rd),
        .data_wr    (data_wr),
        .data_byte  (data_byte),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .mem_wait   (mem_wait),
        .instr_o    (instr_o),
        .rdata_o    (rdata_o),
        .bus_err    (bus_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = free, 1 = on the bus, 2 = completion cycle.
    // Kinds: 0 fetch, 1 load, 2 store.
    int          m_phase = 0, m_kind = 0, m_waited = 0;
    logic        m_byte = 1'b0, m_hi = 1'b0, m_err = 1'b0;
    logic [1:0]  m_be = 2'b00;
    logic [15:0] m_addr = 16'h0, m_wdata = 16'h0, m_instr = 16'h0, m_rdata = 16'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_kind  <= 0;
            m_err   <= 1'b0;
            m_instr <= 16'h0;
            m_rdata <= 16'h0;
        end else begin
            m_err <= 1'b0;
            if (m_phase == 0) begin
                if (data_rd || data_wr) begin
                    m_kind   <= data_wr ? 2 : 1;
                    m_byte   <= data_byte;
                    m_hi     <= data_addr[0];
                    m_addr   <= data_addr & 16'hFFFE;
                    m_be     <= !data_byte ? 2'b11 : (data_addr[0] ? 2'b10 : 2'b01);
                    m_wdata  <= data_byte ? 16'(data_wdata[7:0]) * 16'h0101 : data_wdata;
                    m_phase  <= 1;
                    m_waited <= 0;
                end else if (fetch_req) begin
                    m_kind   <= 0;
                    m_byte   <= 1'b0;
                    m_hi     <= 1'b0;
                    m_addr   <= pc & 16'hFFFE;
                    m_be     <= 2'b11;
                    m_wdata  <= 16'h0;
                    m_phase  <= 1;
                    m_waited <= 0;
                end
            end else if (m_phase == 1) begin
                if (bus.bus_ack === 1'b1) begin
                    if (m_kind == 0) m_instr <= bus.bus_rdata;
                    if (m_kind == 1) m_rdata <= !m_byte ? bus.bus_rdata :
                                                (m_hi ? bus.bus_rdata >> 8 : bus.bus_rdata & 16'h00FF);
                    m_phase <= 2;
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_err <= 1'b1;
                    if (m_kind == 0) m_instr <= 16'hFFFF;
                    if (m_kind == 1) m_rdata <= 16'hFFFF;
                    m_phase <= 2;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("bus_req",   16'(bus.bus_req),   16'(m_phase == 1));
        check("bus_we",    16'(bus.bus_we),    16'(m_phase == 1 && m_kind == 2));
        check("bus_be",    16'(bus.bus_be),    (m_phase == 1) ? 16'(m_be) : 16'h0);
        check("bus_addr",  bus.bus_addr,       (m_phase == 1) ? m_addr : 16'h0);
        check("bus_wdata", bus.bus_wdata,      (m_phase == 1) ? m_wdata : 16'h0);
        check("bus_err",   16'(bus_err),       16'(m_err));
        check("mem_wait",  16'(mem_wait),
              16'(rst && ((m_phase != 2 && (fetch_req || data_rd || data_wr)) ||
                          (m_phase == 2 && fetch_req && m_kind != 0))));
        check("instr_o",   instr_o,            m_instr);
        check("rdata_o",   rdata_o,            m_rdata);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        fetch_req   = 1'b0;
        data_rd     = 1'b0;
        data_wr     = 1'b0;
        data_byte   = 1'b0;
        bus.bus_ack = 1'b0;
    endtask

    int ack_pct;

    initial begin
        rst = 1'b1;
        quiet();
        pc = 16'h0; data_addr = 16'h0; data_wdata = 16'h0; bus.bus_rdata = 16'h0;
        fetch_req = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req",  16'(bus.bus_req), 16'h0);
        check("rst_mem_wait", 16'(mem_wait),    16'h0);
        check("rst_instr",    instr_o,          16'h0);
        check("rst_rdata",    rdata_o,          16'h0);
        quiet();
        rst = 1'b1;

        // Reset in the middle of a bus cycle, then a clean fetch.
        cyc();
        fetch_req = 1'b1; pc = 16'h0040;
        cyc();
        check("midrst_req_before", 16'(bus.bus_req), 16'h1);
        check("midrst_addr",       bus.bus_addr,     16'h0040);
        #3 rst = 1'b0;
        #1;
        check("midrst_req_drop",   16'(bus.bus_req), 16'h0);
        check("midrst_instr",      instr_o,          16'h0);
        @(posedge clk); #1 rst = 1'b1;
        bus.bus_ack = 1'b1; bus.bus_rdata = 16'hCAFE;
        cyc();
        cyc();
        check("postrst_instr", instr_o, 16'hCAFE);
        quiet();
        cyc();

        // Zero-wait fetch.
        fetch_req = 1'b1; pc = 16'h0102; bus.bus_ack = 1'b1; bus.bus_rdata = 16'hA5C3;
        #1 check("zw_wait_c0", 16'(mem_wait), 16'h1);
        cyc();
        check("zw_addr",    bus.bus_addr,  16'h0102);
        check("zw_wait_c1", 16'(mem_wait), 16'h1);
        cyc();
        check("zw_instr",   instr_o,       16'hA5C3);
        check("zw_wait_c2", 16'(mem_wait), 16'h0);
        quiet();
        cyc();

        // Byte store then byte load at an odd address.
        data_wr = 1'b1; data_byte = 1'b1; data_addr = 16'h0201; data_wdata = 16'h0077;
        cyc();
        check("bs_be",    16'(bus.bus_be), 16'h0002);
        check("bs_wdata", bus.bus_wdata,   16'h7777);
        check("bs_we",    16'(bus.bus_we), 16'h1);
        bus.bus_ack = 1'b1;
        cyc();
        quiet();
        cyc();
        data_rd = 1'b1; data_byte = 1'b1; data_addr = 16'h0201;
        cyc();
        bus.bus_ack = 1'b1; bus.bus_rdata = 16'h9911;
        cyc();
        check("bl_rdata", rdata_o, 16'h0099);
        quiet();
        cyc();

        // Data wins over a simultaneous fetch; the fetch follows.
        fetch_req = 1'b1; pc = 16'h0400; data_rd = 1'b1; data_addr = 16'h0300;
        cyc();
        check("pri_first_addr", bus.bus_addr, 16'h0300);
        bus.bus_ack = 1'b1; bus.bus_rdata = 16'h1234;
        cyc();
        check("pri_rdata",     rdata_o,       16'h1234);
        check("pri_wait_done", 16'(mem_wait), 16'h1);
        data_rd = 1'b0; bus.bus_ack = 1'b0;
        cyc();
        check("pri_wait_idle", 16'(mem_wait), 16'h1);
        cyc();
        check("pri_fetch_addr", bus.bus_addr, 16'h0400);
        bus.bus_ack = 1'b1; bus.bus_rdata = 16'hBEEF;
        cyc();
        check("pri_instr",    instr_o,       16'hBEEF);
        check("pri_wait_end", 16'(mem_wait), 16'h0);
        quiet();
        cyc();

        // Three wait states.
        fetch_req = 1'b1; pc = 16'h0500;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("ws_addr_stable", bus.bus_addr,    16'h0500);
            check("ws_be_stable",   16'(bus.bus_be), 16'h0003);
        end
        bus.bus_ack = 1'b1; bus.bus_rdata = 16'h0F0F;
        cyc();
        check("ws_instr", instr_o,      16'h0F0F);
        check("ws_err",   16'(bus_err), 16'h0);
        quiet();
        cyc();

        // Timeout on a fetch.
        fetch_req = 1'b1; pc = 16'h0600;
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc();
            check("to_req_held", 16'(bus.bus_req), 16'h1);
        end
        cyc();
        check("to_err",   16'(bus_err),     16'h1);
        check("to_instr", instr_o,          16'hFFFF);
        check("to_req",   16'(bus.bus_req), 16'h0);
        quiet();
        cyc();
        check("to_err_pulse", 16'(bus_err), 16'h0);

        // Randomized traffic checked by the model.
        ack_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (i % 50 == 0) begin
                case ($urandom_range(3))
                    0: ack_pct = 0;
                    1: ack_pct = 15;
                    2: ack_pct = 60;
                    default: ack_pct = 100;
                endcase
            end
            fetch_req     = ($urandom_range(99) < 50);
            data_rd       = ($urandom_range(99) < 25);
            data_wr       = ($urandom_range(99) < 20);
            data_byte     = $urandom_range(1) == 1;
            pc            = 16'($urandom);
            data_addr     = 16'($urandom);
            data_wdata    = 16'($urandom);
            bus.bus_rdata = 16'($urandom);
            bus.bus_ack   = ($urandom_range(99) < ack_pct);
            if (i % 600 == 300) begin
                #3 rst = 1'b0;
                #1 check("rnd_rst_req", 16'(bus.bus_req), 16'h0);
                @(posedge clk); #1 rst = 1'b1;
            end
        end

        quiet();
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
